// File: rtl/div_seq_if.sv
// div_seq_if: handshake and operand/result bundle between the control unit
// and the sequential divider.
//   divStart         start pulse from the control unit
//   divA, divB       dividend (rs) and divisor (rt), two's complement
//   divHi, divLo     remainder and quotient results
//   divBusy          operation in progress
//   divDone          one-cycle result-valid (or divide-by-zero) pulse
//   divZero          one-cycle divide-by-zero pulse, coincident with divDone
// Modports: master = control unit side, slave = divider side.
interface div_seq_if;
    logic        divStart;
    logic [31:0] divA;
    logic [31:0] divB;
    logic [31:0] divHi;
    logic [31:0] divLo;
    logic        divBusy;
    logic        divDone;
    logic        divZero;

    modport master (
        output divStart, divA, divB,
        input  divHi, divLo, divBusy, divDone, divZero
    );

    modport slave (
        input  divStart, divA, divB,
        output divHi, divLo, divBusy, divDone, divZero
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: sequential signed 32-bit divider with MIPS DIV semantics.
// One restoring step per cycle on operand magnitudes, followed by a sign
// fix-up cycle. Quotient truncates toward zero, remainder takes the sign of
// the dividend. Divide-by-zero is reported without touching HI/LO.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    div_seq_if.slave (start/operands in, results/status out)
// All outputs are registered.
//
// state | meaning
// IDLE  | waiting for divStart; operands sampled here only
// CALC  | 32 restoring shift/subtract steps, one per cycle
// FIX   | apply quotient/remainder signs, load HI/LO
// DONE  | divDone pulse (plus divZero for a zero divisor)
module div_seq (
    input  logic       clk,
    input  logic       reset,
    div_seq_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] rem, rem_next;
    logic [31:0] quo, quo_next;
    logic [31:0] dvsr, dvsr_next;
    logic [5:0]  cnt, cnt_next;
    logic        q_neg, q_neg_next;
    logic        r_neg, r_neg_next;
    logic        by_zero, by_zero_next;

    logic [31:0] hi_q, hi_next;
    logic [31:0] lo_q, lo_next;
    logic        busy_q, busy_next;
    logic        done_q, done_next;
    logic        zero_q, zero_next;

    logic [31:0] abs_a, abs_b;
    logic [32:0] shifted;
    logic [32:0] diff;

    assign abs_a = bus.divA[31] ? (32'd0 - bus.divA) : bus.divA;
    assign abs_b = bus.divB[31] ? (32'd0 - bus.divB) : bus.divB;

    // Partial remainder is always below the divisor, so the shifted value
    // fits in 33 bits and bit 32 of the difference is the borrow.
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvsr};

    always_comb begin
        state_next   = state;
        rem_next     = rem;
        quo_next     = quo;
        dvsr_next    = dvsr;
        cnt_next     = cnt;
        q_neg_next   = q_neg;
        r_neg_next   = r_neg;
        by_zero_next = by_zero;
        hi_next      = hi_q;
        lo_next      = lo_q;

        case (state)
            IDLE: begin
                if (bus.divStart) begin
                    if (bus.divB == 32'd0) begin
                        by_zero_next = 1'b1;
                        state_next   = DONE;
                    end else begin
                        quo_next     = abs_a;
                        dvsr_next    = abs_b;
                        q_neg_next   = bus.divA[31] ^ bus.divB[31];
                        r_neg_next   = bus.divA[31];
                        rem_next     = 32'd0;
                        cnt_next     = 6'd0;
                        by_zero_next = 1'b0;
                        state_next   = CALC;
                    end
                end
            end
            CALC: begin
                if (!diff[32]) begin
                    rem_next = diff[31:0];
                    quo_next = {quo[30:0], 1'b1};
                end else begin
                    rem_next = shifted[31:0];
                    quo_next = {quo[30:0], 1'b0};
                end
                cnt_next = cnt + 6'd1;
                if (cnt == 6'd31) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                lo_next    = q_neg ? (32'd0 - quo) : quo;
                hi_next    = r_neg ? (32'd0 - rem) : rem;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
        zero_next = (state_next == DONE) && by_zero_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rem     <= 32'd0;
            quo     <= 32'd0;
            dvsr    <= 32'd0;
            cnt     <= 6'd0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            by_zero <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state   <= state_next;
            rem     <= rem_next;
            quo     <= quo_next;
            dvsr    <= dvsr_next;
            cnt     <= cnt_next;
            q_neg   <= q_neg_next;
            r_neg   <= r_neg_next;
            by_zero <= by_zero_next;
            hi_q    <= hi_next;
            lo_q    <= lo_next;
            busy_q  <= busy_next;
            done_q  <= done_next;
            zero_q  <= zero_next;
        end
    end

    assign bus.divHi   = hi_q;
    assign bus.divLo   = lo_q;
    assign bus.divBusy = busy_q;
    assign bus.divDone = done_q;
    assign bus.divZero = zero_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized and directed checking of div_seq against a
// behavioural model (64-bit signed arithmetic plus an operation timeline).
module tb_div_seq;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    div_seq_if bus();

    div_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    // Model: an accepted start opens an operation window ending 34 edges
    // later (1 edge for a zero divisor); results appear the cycle before it ends.
    int          cyc = 0;
    int          m_end = 0;
    bit          m_active = 1'b0;
    bit          m_zero = 1'b0;
    bit          was_idle;
    logic [31:0] m_q = 32'd0, m_r = 32'd0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    bit          m_busy = 1'b0, m_done = 1'b0, m_zo = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 1'b0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_zo     = 1'b0;
            m_hi     = 32'd0;
            m_lo     = 32'd0;
        end else begin
            cyc++;
            was_idle = !m_active;
            if (m_active && cyc == m_end) m_active = 1'b0;
            if (was_idle && bus.divStart) begin
                m_active = 1'b1;
                if (bus.divB == 32'd0) begin
                    m_zero = 1'b1;
                    m_end  = cyc + 1;
                end else begin
                    m_zero = 1'b0;
                    m_end  = cyc + 34;
                    ref_div(bus.divA, bus.divB, m_q, m_r);
                end
            end
            m_busy = m_active;
            m_done = m_active && (cyc == m_end - 1);
            m_zo   = m_done && m_zero;
            if (m_done && !m_zero) begin
                m_hi = m_r;
                m_lo = m_q;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, bus.divBusy}, {31'd0, m_busy});
        chk("done", {31'd0, bus.divDone}, {31'd0, m_done});
        chk("zero", {31'd0, bus.divZero}, {31'd0, m_zo});
        chk("hi",   bus.divHi, m_hi);
        chk("lo",   bus.divLo, m_lo);
    end

    // Starts one operation in an IDLE cycle and counts cycles until divDone.
    // If inject > 0, a second start with other operands is pulsed that many
    // cycles after the first.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int inject, output int lat);
        @(negedge clk);
        bus.divStart = 1'b1;
        bus.divA     = a;
        bus.divB     = b;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.divStart = 1'b0;
            if (inject > 0 && lat == inject) begin
                bus.divStart = 1'b1;
                bus.divA     = 32'd50;
                bus.divB     = 32'd5;
            end
            if (inject > 0 && lat == inject + 1) bus.divStart = 1'b0;
        end while (!bus.divDone && lat < 40);
    endtask

    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input int inject, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                            input int exp_lat, input logic exp_zero);
        int lat;
        run_op(a, b, inject, lat);
        chk({name, ".latency"}, lat, exp_lat);
        chk({name, ".lo"}, bus.divLo, exp_lo);
        chk({name, ".hi"}, bus.divHi, exp_hi);
        chk({name, ".zero"}, {31'd0, bus.divZero}, {31'd0, exp_zero});
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'd1;
            4: v = 32'd0 - 32'($urandom_range(1, 40));
            5: v = 32'($urandom_range(1, 40));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        bus.divStart = 1'b0;
        bus.divA     = 32'd0;
        bus.divB     = 32'd0;

        #22;
        chk("rst.hi",   bus.divHi, 32'd0);
        chk("rst.lo",   bus.divLo, 32'd0);
        chk("rst.busy", {31'd0, bus.divBusy}, 32'd0);
        chk("rst.done", {31'd0, bus.divDone}, 32'd0);
        chk("rst.zero", {31'd0, bus.divZero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        directed("7/2",   32'd7,          32'd2,          0, 32'd3,          32'd1,          34, 1'b0);
        directed("-7/2",  32'hFFFF_FFF9,  32'd2,          0, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  34, 1'b0);
        directed("7/-2",  32'd7,          32'hFFFF_FFFE,  0, 32'hFFFF_FFFD,  32'd1,          34, 1'b0);
        directed("3/1",   32'd3,          32'd1,          0, 32'd3,          32'd0,          34, 1'b0);
        directed("5/0",   32'd5,          32'd0,          0, 32'd3,          32'd0,          1,  1'b1);
        directed("ovf",   32'h8000_0000,  32'hFFFF_FFFF,  0, 32'h8000_0000,  32'd0,          34, 1'b0);
        directed("busy",  32'd100,        32'd7,          10, 32'd14,        32'd2,          34, 1'b0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.divStart = 1'b1;
        bus.divA     = 32'd1000;
        bus.divB     = 32'd3;
        @(negedge clk);
        bus.divStart = 1'b0;
        repeat (11) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort.hi",   bus.divHi, 32'd0);
        chk("abort.lo",   bus.divLo, 32'd0);
        chk("abort.busy", {31'd0, bus.divBusy}, 32'd0);
        chk("abort.done", {31'd0, bus.divDone}, 32'd0);
        chk("abort.zero", {31'd0, bus.divZero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        directed("100/7", 32'd100, 32'd7, 0, 32'd14, 32'd2, 34, 1'b0);

        // Random start pulses and operands every cycle, including while busy.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus.divStart = ($urandom_range(0, 4) == 0);
            bus.divA     = rand_op();
            bus.divB     = rand_op();
        end
        bus.divStart = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential signed 32-bit divider implementing MIPS DIV semantics for the multicycle CPU datapath. It sits directly upstream of the HI/LO selection muxes: `divHi` (remainder) and `divLo` (quotient) feed the HI and LO muxes, and the control unit selects them there. The control unit starts the operation with a one-cycle pulse and waits on `divDone` before writing HI/LO. A divide-by-zero is reported on `divZero` for the exception logic.

## Interface
- No parameters. Width is fixed at 32 bits.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `divStart` input 1: start pulse, sampled only in IDLE.
- `divA` input 32: dividend (rs), two's complement. Sampled on the start edge.
- `divB` input 32: divisor (rt), two's complement. Sampled on the start edge.
- `divHi` output 32: remainder. Its sign follows the dividend.
- `divLo` output 32: quotient, truncated toward zero.
- `divBusy` output 1: high while an operation is in progress.
- `divDone` output 1: one-cycle pulse when the result is valid, or when a divide-by-zero is reported.
- `divZero` output 1: one-cycle pulse, coincident with `divDone`, when `divB == 0`.

## Operation
- **FSM states:** IDLE, CALC, FIX, DONE.
- **IDLE**
  - If `divStart == 1` and `divB != 0`:
    - latch the magnitudes |A| and |B| as 32-bit unsigned values;
    - latch the sign flags `qNeg = A[31]^B[31]` and `rNeg = A[31]`;
    - clear the 33-bit partial remainder and the 6-bit iteration counter;
    - go to CALC.
  - If `divStart == 1` and `divB == 0`: go to DONE with the zero flag set. No arithmetic is performed.
  - Otherwise: stay in IDLE.
- **CALC** performs one restoring step per cycle:
  - shift the {remainder, quotient} pair left by 1, bringing in the next dividend MSB;
  - trial-subtract |B|;
  - if the difference is non-negative, keep it and set the quotient LSB to 1; otherwise restore the remainder and set the LSB to 0;
  - the counter increments each cycle; after exactly 32 iterations, go to FIX.
- **FIX** applies the signs:
  - quotient = `qNeg ? -q : q`;
  - remainder = `rNeg ? -r : r`;
  - all results are taken modulo 2^32;
  - load `divHi`/`divLo`, then go to DONE.
- **DONE**
  - Assert `divDone` for one cycle, and `divZero` as well if this is the zero case.
  - Return to IDLE.
- **Output registers:** `divHi`/`divLo` change only in FIX and hold their value until the next successful FIX. A divide-by-zero leaves them unchanged.
- **Overflow case:** -2^31 / -1 falls out of the arithmetic with no special handling and yields `divLo = 0x80000000`, `divHi = 0`. No flag is raised.
- **`divStart` outside IDLE** (CALC/FIX/DONE) is ignored. The operands are not re-sampled.
- **Reset asserted at any time**, including mid-CALC:
  - the FSM goes to IDLE;
  - all outputs go to 0;
  - the in-flight operation is discarded.

## Timing
- **Reset values:** `divHi = 0`, `divLo = 0`, `divBusy = 0`, `divDone = 0`, `divZero = 0`.
- **Normal operation:** `divStart` is sampled high at edge E0.
  - `divBusy` is high from E0 through E0+34, covering CALC, FIX and DONE.
  - CALC occupies the cycles following edges E0 … E0+31.
  - FIX occurs after E0+32, and the results are registered at edge E0+33.
  - `divDone` is high for one cycle following E0+33, with `divHi`/`divLo` already valid in that cycle.
  - IDLE is re-entered at E0+34.
  - Total latency: 34 cycles from start to done.
- **Divide-by-zero:**
  - `divDone` and `divZero` are high together in the single cycle following E0.
  - `divBusy` is high in that same cycle.
  - IDLE is re-entered at E0+1.
- **Back-to-back operation:** a new `divStart` is accepted in the first IDLE cycle after DONE.
- **Outputs:** all outputs are registered; none are combinational paths from the inputs.

## Test plan
- **7 / 2:** `divA = 7`, `divB = 2`, start → after 34 cycles `divLo = 3`, `divHi = 1`, `divDone` high for exactly 1 cycle, `divZero = 0`.
- **Negative dividend:** `divA = -7`, `divB = 2` → `divLo = 0xFFFFFFFD`, `divHi = 0xFFFFFFFF`.
- **Negative divisor:** `divA = 7`, `divB = -2` → `divLo = 0xFFFFFFFD`, `divHi = 1`.
- **Divide-by-zero:**
  - preload a previous result of 3/1;
  - then start with `divA = 5`, `divB = 0` → `divDone` and `divZero` high 1 cycle after start;
  - `divHi`/`divLo` keep 0 / 3.
- **Overflow:** `divA = 0x80000000`, `divB = 0xFFFFFFFF` → `divLo = 0x80000000`, `divHi = 0`.
- **Start-while-busy and reset abort:**
  - issue `divStart` with new operands 10 cycles into CALC → ignored, and the original result arrives at cycle 34;
  - assert `reset` low mid-CALC → all outputs 0 and `divBusy = 0` immediately (asynchronous);
  - after reset is released, a fresh 100/7 gives `divLo = 14`, `divHi = 2`.
